mem_event_monitor: RTL
======================

MEM_EVENT_MONITOR -- requirements
Module: mem_event_monitor

Interface
REQ-001 Parameter LAT_W, default 8, SHALL set the width of the latency counter and output.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the outstanding-cycle count at which timeout_pulse fires; legal range 1..2^LAT_W-1.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 mem_read  input  1  read request from the processor, held high until mem_resp.
REQ-006 mem_write  input  1  write request from the processor, held high until mem_resp.
REQ-007 mem_resp  input  1  memory completion strobe, one cycle per transaction.
REQ-008 req_pulse  output  1  one-cycle pulse per transaction start; drives a performance counter increment.
REQ-009 rd_done_pulse  output  1  one-cycle pulse per completed read.
REQ-010 wr_done_pulse  output  1  one-cycle pulse per completed write.
REQ-011 stall  output  1  high once per cycle spent waiting (request active, mem_resp low).
REQ-012 timeout_pulse  output  1  one-cycle pulse when a transaction reaches TIMEOUT cycles outstanding.
REQ-013 abort_pulse  output  1  one-cycle pulse when a request drops before mem_resp.
REQ-014 latency  output  LAT_W  cycle count of the last completed transaction.
REQ-015 latency_valid  output  1  one-cycle pulse when latency is updated.
REQ-016 proto_err  output  1  sticky flag: mem_read and mem_write were seen high together.

Function
REQ-017 All outputs SHALL be registered; each output reflects the event of cycle N in cycle N+1.
REQ-018 FSM states: IDLE (nothing outstanding) and BUSY (transaction outstanding).
REQ-019 Request active (req) SHALL mean mem_read OR mem_write.
REQ-020 IDLE, req, !mem_resp -> BUSY; req_pulse, stall; count <= 1; latch type (read if mem_read).
REQ-021 IDLE, req, mem_resp -> stay IDLE; req_pulse, done pulse of the type, latency <= 1, latency_valid.
REQ-022 BUSY, req, !mem_resp -> stay BUSY; stall; count increments and saturates at 2^LAT_W-1.
REQ-023 BUSY, mem_resp -> IDLE; done pulse of the latched type; latency <= count+1 (saturating); latency_valid.
REQ-024 BUSY, !req, !mem_resp -> IDLE; abort_pulse; no done pulse; latency unchanged.
REQ-025 mem_resp in IDLE with !req SHALL be ignored (no pulses).
REQ-026 Back-to-back: req high in the cycle after a mem_resp SHALL start a new transaction (req_pulse again).
REQ-027 timeout_pulse SHALL fire exactly once per transaction, on the cycle count first equals TIMEOUT; the FSM stays BUSY.
REQ-028 mem_read and mem_write both high SHALL set proto_err, with the transaction treated as a read.
REQ-029 Transaction type SHALL be latched at start; changes of mem_read/mem_write while BUSY do not change the type.

Reset
REQ-030 reset SHALL force IDLE, zero count and latency, and clear all pulses, stall, and proto_err on the next edge.
REQ-031 reset SHALL take priority over every input event, including mid-transaction; a mem_resp in the reset cycle is discarded.
REQ-032 The first cycle after reset deasserts SHALL evaluate inputs from IDLE.

Structure
REQ-033 Package perf_pkg SHALL hold the state enum (IDLE, BUSY) and the LAT_W default constant.
REQ-034 Sub-module sat_counter (LAT_W, clear, enable, saturating) SHALL implement the outstanding-cycle count.
REQ-035 Pulse outputs SHALL connect one-to-one to the increment inputs of the downstream performance counters.

Verification
REQ-036 mem_read high with mem_resp in the same cycle -> next cycle: req_pulse=1, rd_done_pulse=1, latency=1, latency_valid=1, stall=0.
REQ-037 mem_write held 5 cycles, mem_resp on the 5th -> req_pulse once, stall high 4 cycles, wr_done_pulse once, latency=5.
REQ-038 TIMEOUT=3, mem_read held 10 cycles, then mem_resp -> timeout_pulse exactly once (after count=3), latency=11.
REQ-039 mem_read drops after 2 cycles with no mem_resp -> abort_pulse once; no rd_done_pulse; latency unchanged.
REQ-040 Two back-to-back reads, each 1 cycle wait -> req_pulse twice, rd_done_pulse twice, latency=2 each.
REQ-041 Both requests high, then reset mid-BUSY -> proto_err=1 then cleared; FSM IDLE; a mem_resp in the reset cycle gives no pulse.

Source files
------------

// File: rtl/perf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : perf_pkg
// Description : Shared types and defaults for the memory event monitor.
//               Holds the monitor FSM state encoding and the default latency
//               counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package perf_pkg;

    // Default width of the outstanding-cycle counter and latency output.
    localparam int LAT_W_DEFAULT = 8;

    // IDLE: nothing outstanding. BUSY: a transaction is outstanding.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage : perf_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter holding the outstanding-cycle count of
//               the current memory transaction.
//
// Ports
//   clk         in   clock
//   reset       in   synchronous active-high reset (count -> 0)
//   clear       in   restart the count from zero this cycle
//   enable      in   count one cycle (combined with clear: count becomes 1)
//   count       out  registered count
//   count_inc   out  count + 1, saturated at all-ones (combinational)
//   count_next  out  value count takes at the next edge (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import perf_pkg::*;
#(
    parameter int LAT_W = LAT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [LAT_W-1:0] count,
    output logic [LAT_W-1:0] count_inc,
    output logic [LAT_W-1:0] count_next
);

    localparam logic [LAT_W-1:0] CNT_MAX = '1;
    localparam logic [LAT_W-1:0] CNT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

    always_comb begin
        count_inc = (count == CNT_MAX) ? count : count + 1'b1;
    end

    // Clear and enable together mean "a new transaction's first cycle",
    // so the count restarts at one rather than zero.
    always_comb begin
        if (clear) begin
            count_next = enable ? CNT_ONE : '0;
        end else if (enable) begin
            count_next = count_inc;
        end else begin
            count_next = count;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/mem_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : mem_event_monitor
// Description : Watches a processor/memory request handshake and produces
//               registered event pulses for performance counters: request
//               starts, read/write completions, stall cycles, timeouts,
//               aborts, and the latency of the last completed transaction.
//
// Ports
//   clk            in   clock
//   reset          in   synchronous active-high reset
//   mem_read       in   read request, held until mem_resp
//   mem_write      in   write request, held until mem_resp
//   mem_resp       in   one-cycle completion strobe
//   req_pulse      out  transaction start
//   rd_done_pulse  out  read completed
//   wr_done_pulse  out  write completed
//   stall          out  one cycle spent waiting for mem_resp
//   timeout_pulse  out  transaction reached TIMEOUT outstanding cycles
//   abort_pulse    out  request dropped before mem_resp
//   latency        out  cycle count of the last completed transaction
//   latency_valid  out  latency was updated
//   proto_err      out  sticky: read and write requested together
// Revision    : 1.0 - initial release
// ============================================================================
module mem_event_monitor
    import perf_pkg::*;
#(
    parameter int LAT_W   = LAT_W_DEFAULT,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             mem_resp,
    output logic             req_pulse,
    output logic             rd_done_pulse,
    output logic             wr_done_pulse,
    output logic             stall,
    output logic             timeout_pulse,
    output logic             abort_pulse,
    output logic [LAT_W-1:0] latency,
    output logic             latency_valid,
    output logic             proto_err
);

    localparam logic [LAT_W-1:0] TIMEOUT_VAL = LAT_W'(TIMEOUT);
    localparam logic [LAT_W-1:0] LAT_ONE     = {{(LAT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic             req;
    logic             type_read;
    logic             type_read_next;

    logic             cnt_clear;
    logic             cnt_enable;
    logic [LAT_W-1:0] count;
    logic [LAT_W-1:0] count_inc;
    logic [LAT_W-1:0] count_next;

    logic             req_pulse_d;
    logic             rd_done_d;
    logic             wr_done_d;
    logic             stall_d;
    logic             timeout_d;
    logic             abort_d;
    logic [LAT_W-1:0] latency_d;
    logic             latency_valid_d;
    logic             proto_err_d;

    assign req = mem_read | mem_write;

    sat_counter #(
        .LAT_W (LAT_W)
    ) u_cycle_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear      (cnt_clear),
        .enable     (cnt_enable),
        .count      (count),
        .count_inc  (count_inc),
        .count_next (count_next)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            type_read <= 1'b0;
        end else begin
            state     <= state_next;
            type_read <= type_read_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req && !mem_resp) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // Completion wins over a dropped request in the same cycle.
                if (mem_resp || !req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        cnt_clear       = 1'b0;
        cnt_enable      = 1'b0;
        type_read_next  = type_read;
        req_pulse_d     = 1'b0;
        rd_done_d       = 1'b0;
        wr_done_d       = 1'b0;
        stall_d         = 1'b0;
        abort_d         = 1'b0;
        latency_d       = latency;
        latency_valid_d = 1'b0;

        case (state)
            IDLE: begin
                // Keep the counter at zero while idle so a new transaction
                // always starts from a known value.
                cnt_clear = 1'b1;
                if (req) begin
                    req_pulse_d = 1'b1;
                    if (mem_resp) begin
                        // Zero-wait transaction: a read wins if both are set.
                        rd_done_d       = mem_read;
                        wr_done_d       = !mem_read;
                        latency_d       = LAT_ONE;
                        latency_valid_d = 1'b1;
                    end else begin
                        cnt_enable     = 1'b1;
                        stall_d        = 1'b1;
                        type_read_next = mem_read;
                    end
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    rd_done_d       = type_read;
                    wr_done_d       = !type_read;
                    latency_d       = count_inc;
                    latency_valid_d = 1'b1;
                    cnt_clear       = 1'b1;
                end else if (req) begin
                    cnt_enable = 1'b1;
                    stall_d    = 1'b1;
                end else begin
                    abort_d   = 1'b1;
                    cnt_clear = 1'b1;
                end
            end
            default: begin
                cnt_clear = 1'b1;
            end
        endcase

        // The count only rises while a transaction is outstanding and sticks
        // once saturated, so "next equals TIMEOUT and current does not" marks
        // the single crossing of this transaction.
        timeout_d   = cnt_enable && (count_next == TIMEOUT_VAL) && (count != TIMEOUT_VAL);
        proto_err_d = proto_err | (mem_read & mem_write);
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            req_pulse     <= 1'b0;
            rd_done_pulse <= 1'b0;
            wr_done_pulse <= 1'b0;
            stall         <= 1'b0;
            timeout_pulse <= 1'b0;
            abort_pulse   <= 1'b0;
            latency       <= '0;
            latency_valid <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            req_pulse     <= req_pulse_d;
            rd_done_pulse <= rd_done_d;
            wr_done_pulse <= wr_done_d;
            stall         <= stall_d;
            timeout_pulse <= timeout_d;
            abort_pulse   <= abort_d;
            latency       <= latency_d;
            latency_valid <= latency_valid_d;
            proto_err     <= proto_err_d;
        end
    end

endmodule : mem_event_monitor
`default_nettype wire
